// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encoding, keypad bit map
// and the run/pause state used by the input conditioning stage and the game FSM.
package snake_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;
  localparam int KEY_PAUSE = 4;
  localparam int NUM_KEYS  = 8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

  // Opposite pairs differ only in bit 0: left/right = 0/1, down/up = 2/3.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One keypad bit: 2-FF synchroniser, counter debounce and a one-cycle pulse
// on each debounced rising edge.
module key_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_pulse
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;
  logic        r_stable_d;
  logic        r_pulse;
  logic [15:0] r_cnt;

  logic        w_differs;
  logic        w_settled;

  assign w_differs = (r_sync2 != r_stable);
  assign w_settled = w_differs && (r_cnt == DEBOUNCE_CYCLES - 16'd1);

  // NOTE: every register here uses <= so all of them sample pre-edge values;
  // with = the synchroniser would collapse into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_key;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
      if (w_settled) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/snake_input_ctrl.sv
// Keypad conditioning for the snake game: debounced key pulses, pending
// direction with reversal rejection, pause toggle and the periodic step pulse.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] STEP_CYCLES     = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keypad,
  output logic [1:0] dir,
  output logic       step,
  output logic       paused,
  output logic [7:0] key_pulse,
  output logic       dir_changed
);

  logic [NUM_KEYS-1:0] w_key_pulse;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_key  (keypad[g]),
      .o_pulse(w_key_pulse[g])
    );
  end

  run_state_e  r_state;
  run_state_e  w_state_next;
  logic [31:0] r_step_cnt;
  logic [1:0]  r_pending;
  logic [1:0]  r_dir;
  logic        r_step;
  logic        r_dir_changed;

  logic        w_terminal;
  logic        w_has_cand;
  logic [1:0]  w_cand;
  logic [1:0]  w_ref;
  logic        w_accept;

  // rst is expected to be released synchronously to clk by its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps this block free of latches
  // whatever branch is taken.
  always_comb begin
    w_state_next = r_state;
    if (w_key_pulse[KEY_PAUSE]) begin
      case (r_state)
        ST_RUN:    w_state_next = ST_PAUSED;
        ST_PAUSED: w_state_next = ST_RUN;
        default:   w_state_next = ST_RUN;
      endcase
    end
  end

  assign w_terminal = (r_state == ST_RUN) && (r_step_cnt == STEP_CYCLES - 32'd1);

  // Only the highest-priority pulse is a candidate; a rejected one does not
  // fall through to lower-priority keys.
  always_comb begin
    w_has_cand = 1'b1;
    w_cand     = DIR_LEFT;
    if (w_key_pulse[KEY_LEFT]) begin
      w_cand = DIR_LEFT;
    end else if (w_key_pulse[KEY_RIGHT]) begin
      w_cand = DIR_RIGHT;
    end else if (w_key_pulse[KEY_DOWN]) begin
      w_cand = DIR_DOWN;
    end else if (w_key_pulse[KEY_UP]) begin
      w_cand = DIR_UP;
    end else begin
      w_has_cand = 1'b0;
    end
  end

  // On a commit edge pending becomes dir, so it is the direction to guard.
  assign w_ref    = w_terminal ? r_pending : r_dir;
  assign w_accept = w_has_cand && (r_state == ST_RUN) && !w_key_pulse[KEY_PAUSE] &&
                    (w_cand != opposite_dir(w_ref));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_cnt    <= '0;
      r_pending     <= DIR_RIGHT;
      r_dir         <= DIR_RIGHT;
      r_step        <= 1'b0;
      r_dir_changed <= 1'b0;
    end else begin
      if (w_terminal) begin
        r_step_cnt <= '0;
        r_dir      <= r_pending;
      end else if (r_state == ST_RUN) begin
        r_step_cnt <= r_step_cnt + 32'd1;
      end
      if (w_accept) begin
        r_pending <= w_cand;
      end
      r_step        <= w_terminal;
      r_dir_changed <= w_terminal && (r_pending != r_dir);
    end
  end

  assign dir         = r_dir;
  assign step        = r_step;
  assign paused      = (r_state == ST_PAUSED);
  assign key_pulse   = w_key_pulse;
  assign dir_changed = r_dir_changed;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=16:
// a direction vector table plus hand sequences for bounce, step-cycle press,
// pause and asynchronous reset.
module tb_snake_input_ctrl;

  localparam logic [15:0] DEB = 16'd4;
  localparam logic [31:0] STP = 32'd16;

  logic       clk;
  logic       rst;
  logic [7:0] keypad;
  logic [1:0] dir;
  logic       step;
  logic       paused;
  logic [7:0] key_pulse;
  logic       dir_changed;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] mask_a;
    logic [7:0] mask_b;
    logic [1:0] exp_dir;
    logic       exp_chg;
  } vec_t;

  vec_t vecs [11];

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STEP_CYCLES    (STP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad     (keypad),
    .dir        (dir),
    .step       (step),
    .paused     (paused),
    .key_pulse  (key_pulse),
    .dir_changed(dir_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until step is seen; n is the number of edges taken, -1 on timeout.
  task automatic wait_step(input int limit, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      tick();
      n++;
      if (step) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL step_timeout: no step within %0d cycles", limit);
      n = -1;
    end
  endtask

  initial begin
    int   n;
    int   pulses;
    int   pulse_at;
    int   steps_seen;
    int   unpaused;
    int   left_pulses;
    logic found;

    // Starting state: dir=up, pending=up (after the bounce sequence).
    vecs[0]  = '{8'h04, 8'h00, 2'd3, 1'b0};  // down: reversal of up
    vecs[1]  = '{8'h01, 8'h00, 2'd0, 1'b1};  // left accepted
    vecs[2]  = '{8'h0A, 8'h00, 2'd0, 1'b0};  // right wins over up, rejected, up not tried
    vecs[3]  = '{8'h08, 8'h02, 2'd3, 1'b1};  // up accepted, later right rejected
    vecs[4]  = '{8'h0C, 8'h00, 2'd3, 1'b0};  // down wins over up, reversal
    vecs[5]  = '{8'h03, 8'h00, 2'd0, 1'b1};  // left wins over right
    vecs[6]  = '{8'h04, 8'h02, 2'd2, 1'b1};  // down accepted, right rejected vs left
    vecs[7]  = '{8'h0B, 8'h00, 2'd0, 1'b1};  // left wins among three
    vecs[8]  = '{8'h00, 8'h00, 2'd0, 1'b0};  // idle
    vecs[9]  = '{8'h08, 8'h00, 2'd3, 1'b1};  // up
    vecs[10] = '{8'h06, 8'h00, 2'd1, 1'b1};  // right wins over down, accepted

    // ---- reset state and idle stepping ----
    rst    = 1'b1;
    keypad = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_key_pulse", 32'(key_pulse), 32'd0);
    check("rst_dir_changed", 32'(dir_changed), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("idle_step", 32'(step), 32'((k == 16) || (k == 32)));
      check("idle_dir", 32'(dir), 32'd1);
      check("idle_dir_changed", 32'(dir_changed), 32'd0);
      check("idle_paused", 32'(paused), 32'd0);
    end

    // ---- bounce on up, then clean hold ----
    wait_step(40, n);
    keypad[3] = 1'b1;
    tick();
    keypad[3] = 1'b0;
    tick();
    keypad[3] = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int k = 3; k <= 16; k++) begin
      tick();
      if (key_pulse[3]) begin
        pulses++;
        pulse_at = k;
      end
      if (k == 10) keypad[3] = 1'b0;
      if (k == 16) begin
        check("bounce_step", 32'(step), 32'd1);
        check("bounce_dir", 32'(dir), 32'd3);
        check("bounce_dir_changed", 32'(dir_changed), 32'd1);
      end
    end
    check("bounce_pulse_count", 32'(pulses), 32'd1);
    check("bounce_pulse_cycle", 32'(pulse_at), 32'd9);

    // ---- direction vector table, one step window per vector ----
    for (int v = 0; v < 11; v++) begin
      keypad = vecs[v].mask_a;
      tick();
      keypad = vecs[v].mask_a | vecs[v].mask_b;
      for (int k = 2; k <= 9; k++) begin
        tick();
        if (k == 6) check("vec_pulse_early", 32'(key_pulse), 32'd0);
        if (k == 7) check("vec_pulse_a", 32'(key_pulse), 32'(vecs[v].mask_a));
        if (k == 8) check("vec_pulse_b", 32'(key_pulse), 32'(vecs[v].mask_b));
      end
      keypad = 8'h00;
      wait_step(20, n);
      check("vec_step_period", 32'(n), 32'd7);
      check("vec_dir", 32'(dir), 32'(vecs[v].exp_dir));
      check("vec_dir_changed", 32'(dir_changed), 32'(vecs[v].exp_chg));
    end

    // ---- down press landing in the step cycle, pending=up, dir=right ----
    keypad = 8'h08;
    for (int k = 1; k <= 9; k++) tick();
    keypad = 8'h04;
    for (int k = 10; k <= 16; k++) begin
      tick();
      if (k == 16) begin
        check("stepcyc_step", 32'(step), 32'd1);
        check("stepcyc_pulse", 32'(key_pulse), 32'h04);
        check("stepcyc_dir", 32'(dir), 32'd3);
        check("stepcyc_dir_changed", 32'(dir_changed), 32'd1);
      end
    end
    tick();
    keypad = 8'h00;
    wait_step(20, n);
    check("stepcyc_next_period", 32'(n), 32'd15);
    check("stepcyc_next_dir", 32'(dir), 32'd3);
    check("stepcyc_next_dir_changed", 32'(dir_changed), 32'd0);

    // ---- pause at counter=5, ignored press, unpause ----
    for (int k = 1; k <= 14; k++) tick();
    keypad = 8'h10;
    for (int k = 15; k <= 24; k++) begin
      tick();
      if (k == 16) check("pause_prior_step", 32'(step), 32'd1);
      if (k == 21) begin
        check("pause_pulse", 32'(key_pulse), 32'h10);
        check("pause_not_yet", 32'(paused), 32'd0);
      end
      if (k == 22) check("pause_set", 32'(paused), 32'd1);
    end
    keypad = 8'h00;
    steps_seen  = 0;
    unpaused    = 0;
    left_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (step) steps_seen++;
      if (!paused) unpaused++;
      if (key_pulse[0]) left_pulses++;
      if (i == 20) keypad = 8'h01;
      if (i == 35) keypad = 8'h00;
    end
    check("paused_steps", 32'(steps_seen), 32'd0);
    check("paused_held", 32'(unpaused), 32'd0);
    check("paused_left_seen", 32'(left_pulses), 32'd1);
    keypad = 8'h10;
    found  = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (key_pulse[4]) found = 1'b1;
    end
    check("unpause_pulse", 32'(found), 32'd1);
    check("unpause_still_paused", 32'(paused), 32'd1);
    tick();
    check("unpause_cleared", 32'(paused), 32'd0);
    n = 0;
    found = 1'b0;
    while (!found && n < 30) begin
      tick();
      n++;
      if (n == 3) keypad = 8'h00;
      if (step) found = 1'b1;
    end
    check("unpause_step_delay", 32'(n), 32'd10);
    check("unpause_dir", 32'(dir), 32'd3);
    check("unpause_dir_changed", 32'(dir_changed), 32'd0);

    // ---- asynchronous reset mid-debounce and mid-count ----
    for (int k = 1; k <= 5; k++) tick();
    keypad = 8'h04;
    for (int k = 1; k <= 3; k++) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_dir", 32'(dir), 32'd1);
    check("async_rst_step", 32'(step), 32'd0);
    check("async_rst_paused", 32'(paused), 32'd0);
    check("async_rst_key_pulse", 32'(key_pulse), 32'd0);
    check("async_rst_dir_changed", 32'(dir_changed), 32'd0);
    keypad = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n      = 0;
    pulses = 0;
    found  = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (key_pulse != 8'h00) pulses++;
      if (step) found = 1'b1;
    end
    check("post_rst_step_delay", 32'(n), 32'd16);
    check("post_rst_no_pulse", 32'(pulses), 32'd0);
    check("post_rst_dir", 32'(dir), 32'd1);
    check("post_rst_dir_changed", 32'(dir_changed), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
